// File: rtl/jpeg_bit_packer.sv
// Packs right-aligned variable-length Huffman codes MSB-first into a byte stream,
// inserting a 0x00 after every 0xFF and padding the last partial byte with 1s on flush.
module jpeg_bit_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        code_valid,
    output logic        code_ready,
    input  logic [15:0] code_bits,
    input  logic [4:0]  code_len,
    input  logic        flush,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        flush_done
);

    localparam int unsigned CODE_W = 16;
    localparam int unsigned LEN_W  = 5;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned FILL_W = 6;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {RUN, PAD, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [ACC_W-1:0]    acc, acc_shift, acc_pack, acc_nxt, placed, pad_mask;
    logic [FILL_W-1:0]   fill, fill_shift, fill_pack, fill_up, fill_nxt, place_sh;
    logic                stuff_pending;
    logic                out_free, do_stuff, do_extract, accept;
    logic [LEN_W-1:0]    len_eff;
    logic [CODE_W-1:0]   code_mask, code_masked;

    assign code_ready = (state == RUN) && (fill <= FILL_W'(16));

    // Byte extraction uses pre-edge fill; code placement and padding use the post-shift view.
    always_comb begin
        out_free    = !byte_valid || byte_ready;
        do_stuff    = out_free && stuff_pending;
        do_extract  = out_free && !stuff_pending && (fill >= FILL_W'(8));
        accept      = code_valid && code_ready;
        len_eff     = (code_len > LEN_W'(16)) ? LEN_W'(16) : code_len;
        code_mask   = CODE_W'((17'h1 << len_eff) - 17'h1);
        code_masked = code_bits & code_mask;

        acc_shift   = do_extract ? {acc[ACC_W-BYTE_W-1:0], BYTE_W'(0)} : acc;
        fill_shift  = do_extract ? (fill - FILL_W'(8)) : fill;

        place_sh    = FILL_W'(32) - fill_shift - FILL_W'(len_eff);
        placed      = accept ? ({{(ACC_W-CODE_W){1'b0}}, code_masked} << place_sh) : '0;
        acc_pack    = acc_shift | placed;
        fill_pack   = accept ? (fill_shift + FILL_W'(len_eff)) : fill_shift;

        // Ones from the current fill point up to the next byte boundary.
        fill_up     = (fill_pack + FILL_W'(7)) & FILL_W'(6'b111000);
        pad_mask    = (32'hFFFF_FFFF >> fill_pack) & ~(32'hFFFF_FFFF >> fill_up);

        acc_nxt     = acc_pack;
        fill_nxt    = fill_pack;
        if (state == PAD) begin
            acc_nxt  = acc_pack | pad_mask;
            fill_nxt = fill_up;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (flush) state_nxt = PAD;
            PAD:     state_nxt = DRAIN;
            DRAIN:   if ((fill == '0) && !stuff_pending && !byte_valid) state_nxt = DONE;
            DONE:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Accumulator, output byte register and stuff tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc           <= '0;
            fill          <= '0;
            stuff_pending <= 1'b0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            flush_done    <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            fill       <= fill_nxt;
            flush_done <= (state_nxt == DONE);
            if (do_stuff) begin
                byte_data     <= '0;
                byte_valid    <= 1'b1;
                stuff_pending <= 1'b0;
            end else if (do_extract) begin
                byte_data     <= acc[ACC_W-1 -: BYTE_W];
                byte_valid    <= 1'b1;
                stuff_pending <= (acc[ACC_W-1 -: BYTE_W] == 8'hFF);
            end else if (out_free) begin
                byte_valid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jpeg_bit_packer.sv
// Scoreboard bench for jpeg_bit_packer: directed codes push hand-computed bytes,
// a negedge monitor pops and compares on every byte handshake and flush_done pulse.
module tb_jpeg_bit_packer;

    localparam logic [8:0] DONE_MARK = 9'h100;

    logic        clock;
    logic        reset_n;
    logic        code_valid;
    logic        code_ready;
    logic [15:0] code_bits;
    logic [4:0]  code_len;
    logic        flush;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        flush_done;

    int          n_checks;
    int          n_fail;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e;
    logic        held;
    logic [7:0]  held_data;

    jpeg_bit_packer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code_bits  (code_bits),
        .code_len   (code_len),
        .flush      (flush),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .flush_done (flush_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: byte handshakes and flush_done pulses are popped in order from the scoreboard.
    always @(negedge clock) begin
        if (!reset_n) begin
            held = 1'b0;
        end else begin
            if (held && byte_valid)
                check("byte_hold", {24'h0, byte_data}, {24'h0, held_data});
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", byte_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("byte_data", {23'h0, 1'b0, byte_data}, {23'h0, mon_e});
                end
            end
            if (flush_done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_flush_done: got pulse expected none at %0t", $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("flush_done_order", {23'h0, DONE_MARK}, {23'h0, mon_e});
                end
            end
            held      = byte_valid && !byte_ready;
            held_data = byte_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_code(input logic [15:0] b, input logic [4:0] l);
        int n = 0;
        code_bits  = b;
        code_len   = l;
        code_valid = 1'b1;
        while (!code_ready && n < 100) begin
            tick();
            n++;
        end
        check("code_ready_wait", {31'h0, code_ready}, 32'h1);
        tick();
        code_valid = 1'b0;
        code_bits  = '0;
        code_len   = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_empty(input bit toggle);
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            if (toggle) byte_ready = !byte_ready;
            tick();
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        byte_ready = 1'b1;
    endtask

    task automatic push_bytes(input logic [8:0] v[]);
        foreach (v[i]) exp_q.push_back(v[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        held       = 1'b0;
        reset_n    = 1'b1;
        code_valid = 1'b0;
        code_bits  = '0;
        code_len   = '0;
        flush      = 1'b0;
        byte_ready = 1'b0;
        #2 reset_n = 1'b0;

        // Reset with inputs toggling.
        for (int i = 0; i < 4; i++) begin
            tick();
            code_valid = ~code_valid;
            flush      = ~flush;
            byte_ready = ~byte_ready;
            code_bits  = 16'($urandom);
            code_len   = 5'($urandom_range(31, 0));
            #1;
            check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
            check("rst_byte_data", {24'h0, byte_data}, 32'h0);
            check("rst_flush_done", {31'h0, flush_done}, 32'h0);
            check("rst_code_ready", {31'h0, code_ready}, 32'h1);
        end
        code_valid = 1'b0;
        flush      = 1'b0;
        code_bits  = '0;
        code_len   = '0;
        byte_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_no_byte", {31'h0, byte_valid}, 32'h0);
        end

        // 101 + (len 0 ignored) + 11110 -> 0xBE; bits above len ignored.
        push_bytes('{9'h0BE});
        send_code(16'hFFFD, 5'd3);
        send_code(16'hFFFF, 5'd0);
        send_code(16'h001E, 5'd5);
        wait_empty(1'b0);
        tick();
        tick();
        check("be_valid_drop", {31'h0, byte_valid}, 32'h0);

        // Length above 16 behaves as 16.
        push_bytes('{9'h012, 9'h034});
        send_code(16'h1234, 5'd31);
        wait_empty(1'b0);

        // 0xFFFF with toggling ready: FF 00 FF 00.
        push_bytes('{9'h0FF, 9'h000, 9'h0FF, 9'h000});
        send_code(16'hFFFF, 5'd16);
        wait_empty(1'b1);

        // 010 then flush -> 0x5F, flush_done.
        push_bytes('{9'h05F, DONE_MARK});
        send_code(16'h0002, 5'd3);
        do_flush();
        wait_empty(1'b0);
        tick();
        check("run_after_done", {31'h0, code_ready}, 32'h1);

        // 1 then flush -> 0xFF padded, stuffed 0x00, flush_done.
        push_bytes('{9'h0FF, 9'h000, DONE_MARK});
        send_code(16'h0001, 5'd1);
        do_flush();
        wait_empty(1'b0);

        // Backpressure with 16-bit codes.
        tick();
        byte_ready = 1'b0;
        push_bytes('{9'h0A1, 9'h0B2, 9'h0C3, 9'h0D4, 9'h0E5, 9'h0F6, 9'h007, 9'h018, DONE_MARK});
        send_code(16'hA1B2, 5'd16);
        send_code(16'hC3D4, 5'd16);
        check("bp_ready_low", {31'h0, code_ready}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ready_hold", {31'h0, code_ready}, 32'h0);
        end
        byte_ready = 1'b1;
        send_code(16'hE5F6, 5'd16);
        send_code(16'h0718, 5'd16);
        do_flush();
        wait_empty(1'b0);

        // Reset during DRAIN with a byte held.
        tick();
        byte_ready = 1'b0;
        send_code(16'hBEEF, 5'd16);
        do_flush();
        tick();
        tick();
        check("pre_reset_valid", {31'h0, byte_valid}, 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        check("mid_rst_byte_data", {24'h0, byte_data}, 32'h0);
        check("mid_rst_flush_done", {31'h0, flush_done}, 32'h0);
        check("mid_rst_code_ready", {31'h0, code_ready}, 32'h1);
        tick();
        reset_n    = 1'b1;
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_idle", {31'h0, byte_valid}, 32'h0);
        end
        push_bytes('{9'h0A5});
        send_code(16'h00A5, 5'd8);
        wait_empty(1'b0);
        for (int i = 0; i < 4; i++) tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_packer.md
# jpeg_bit_packer

Packs the variable-length Huffman codes produced by the per-channel JPEG encoder into a byte stream. Inserts the JPEG-mandated 0x00 stuff byte after every emitted 0xFF. On request, pads the final partial byte with 1s. Sits directly downstream of the encoder's `huffman_code` / `huffman_code_length` / `jpeg_out_enable` outputs and feeds the byte-wide output/file writer.

## Interface
Parameters:
- None. Widths are fixed: code 16 bits, length 5 bits, accumulator 32 bits.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `code_valid`  in  1  `code_bits`/`code_len` are valid this cycle.
- `code_ready`  out  1  block can accept a code this cycle.
- `code_bits`  in  16  code, right-aligned, emitted MSB first; bits above `code_len` are ignored.
- `code_len`  in  5  number of valid bits, 0..16; values 17..31 are treated as 16.
- `flush`  in  1  one-cycle request to pad and drain all buffered bits.
- `byte_valid`  out  1  `byte_data` is valid; held until accepted.
- `byte_data`  out  8  output byte.
- `byte_ready`  in  1  downstream accepts the byte when `byte_valid` and `byte_ready` are both high.
- `flush_done`  out  1  one-cycle pulse when a flush completes.

## Operation
- State: `acc[31:0]`, MSB-aligned, with valid bits at `acc[31 -: fill]`. `fill` ranges 0..32. `stuff_pending` is 1 bit. FSM is `RUN`, `PAD`, `DRAIN`, `DONE`.
- `code_ready = (state == RUN) && (fill <= 16)`. It is combinational from registered state.
- Accept (`code_valid && code_ready`):
  - Place the masked code at `acc` bit positions `[31 - f' -: len]`, where `f'` is `fill` after any same-cycle byte extraction.
  - Then `fill <= f' + len`.
  - A `len == 0` code is accepted with no effect.
- Output register is free when `!byte_valid || byte_ready`. When free, in priority order:
  1. If `stuff_pending`, load 0x00 and clear `stuff_pending`.
  2. Otherwise, if `fill >= 8` (registered value), load `acc[31:24]`, shift `acc` left 8, `fill -= 8`. If the loaded byte is 0xFF, set `stuff_pending`.
  3. Otherwise, drop `byte_valid`.
- Extraction decisions use the pre-edge `fill`. Acceptance placement uses the post-extraction `f'`. Both can occur in the same cycle.
- FSM transitions:
  - `RUN`: on `flush`, go to `PAD`. A code accepted in the same cycle as `flush` is packed before padding.
  - `PAD` (1 cycle): if `fill % 8 != 0`, set the bits from `fill` up to the next byte boundary to 1 and round `fill` up. Go to `DRAIN`. If the byte path shifts `acc` in this same cycle, padding applies to the post-shift value.
  - `DRAIN`: stay until `fill == 0`, `!stuff_pending` and `!byte_valid`, then go to `DONE`.
  - `DONE` (1 cycle): `flush_done = 1`, go to `RUN`.
- `flush` asserted outside `RUN` is ignored.
- Padding with 1s can produce 0xFF. It is stuffed like any other 0xFF.

## Timing
- Reset values:
  - `byte_valid = 0`, `byte_data = 0x00`, `flush_done = 0`.
  - `acc = 0`, `fill = 0`, `stuff_pending = 0`, state `RUN`.
  - `code_ready = 1` while in reset and after it.
- Latency: a code accepted at edge N that raises `fill` to at least 8 shows its first byte on `byte_valid`/`byte_data` after edge N+1, provided the output register is free.
- Throughput: at most 1 code and 1 byte per cycle. Sustained 16-bit codes throttle `code_ready` to match the 1 byte/cycle drain.
- `byte_data` must not change while `byte_valid && !byte_ready`.
- Stuffing: 0x00 follows its 0xFF on the next handshake slot. No other byte may intervene.
- `flush_done` minimum: pulses 3 cycles after a `flush` with `fill == 0` and an idle output, i.e. through `PAD`, then `DRAIN`, then `DONE`.
- Reset asserted mid-operation (including `PAD`, `DRAIN` or pending stuff) clears all state immediately. Buffered bits are discarded and no `flush_done` is issued.

## Test plan
- Reset with inputs toggling: all outputs 0, `code_ready = 1`; after release, no `byte_valid` without codes.
- Code 0b101 with len 3, then 0b11110 with len 5, `byte_ready = 1`: exactly one byte 0xBE, then `byte_valid` drops.
- Code 0xFFFF with len 16: bytes FF, 00, FF, 00 in order; `stuff_pending` never lost under `byte_ready` toggling every other cycle.
- Code 0b010 with len 3, then `flush`: one byte 0x5F, then a `flush_done` pulse only after that byte is accepted. Code 0b1 with len 1, then `flush`: byte 0xFF followed by 0x00, then `flush_done`.
- Backpressure: hold `byte_ready = 0` for 10 cycles while driving len-16 codes. `code_ready` falls once `fill > 16`, `byte_data` holds stable, and after release the byte stream matches the concatenated code bits with no loss or duplication.
- Reset asserted during `DRAIN` with `byte_valid = 1`: outputs return to reset values the same cycle, with no `flush_done`. A new code 0xA5 with len 8 then yields 0xA5.
